// File: rtl/lgn_class_argmax.sv
// lgn_class_argmax: multi-cycle per-class popcount and argmax unit.
//   The CLASSES*N net outputs split into CLASSES groups of N bits. Each group
//   is popcounted CHUNK bits per cycle, so the adder depth stays bounded. The
//   class scores are then scanned one per cycle to find the winner.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request a classification of the current y (IDLE/DONE only)
//   y           net outputs; class c owns y[c*N +: N]; hold stable while busy
//   score_sel   class index for score readback
//   busy        high while accumulating or scanning
//   done        one-cycle result-valid pulse
//   class_out   winning class index, held until the next completion
//   max_score   winning class score, held until the next completion
//   score_out   score[score_sel], or 0 when score_sel >= CLASSES

// Per-class score accumulator: clear, or add the popcount of one chunk.
module lgn_class_argmax_lane #(
  parameter int CHUNK = 40,
  parameter int SW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc,
  input  logic [CHUNK-1:0] chunk,
  output logic [SW-1:0]    score
);
  localparam int PW = $clog2(CHUNK + 1);

  logic [PW-1:0] pc;
  logic [SW-1:0] score_d, score_q;

  always_comb begin
    pc = '0;
    for (int b = 0; b < CHUNK; b++) pc = pc + PW'(chunk[b]);
    score_d = score_q;
    if (clr)      score_d = '0;
    else if (acc) score_d = score_q + SW'(pc);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) score_q <= '0;
    else        score_q <= score_d;

  assign score = score_q;
endmodule

module lgn_class_argmax #(
  parameter  int CLASSES = 10,
  parameter  int N       = 400,
  parameter  int CHUNK   = 40,
  localparam int STEPS   = N / CHUNK,
  localparam int SW      = $clog2(N + 1),
  localparam int CW      = (CLASSES > 1) ? $clog2(CLASSES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CLASSES*N-1:0] y,
  input  logic [CW-1:0]        score_sel,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        class_out,
  output logic [SW-1:0]        max_score,
  output logic [SW-1:0]        score_out
);
  localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_ARGMAX = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  generate
    if (N % CHUNK != 0) begin : g_bad_chunk
      $error("lgn_class_argmax: N must be a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]    state_d, state_q;
  logic [KW-1:0] k_d, k_q;
  logic [CW-1:0] i_d, i_q;
  logic [SW-1:0] best_d, best_q;
  logic [CW-1:0] best_idx_d, best_idx_q;
  logic [CW-1:0] class_out_d, class_out_q;
  logic [SW-1:0] max_score_d, max_score_q;

  logic                       clr, acc;
  logic [CLASSES-1:0][SW-1:0] scores;
  logic [SW-1:0]              cur_score, nb;
  logic [CW-1:0]              ni;

  // Per-class lanes; each picks its k-th chunk through a constant-index mux.
  for (genvar c = 0; c < CLASSES; c++) begin : g_lane
    logic [N-1:0]     grp;
    logic [CHUNK-1:0] chunk;
    assign grp = y[c*N +: N];
    always_comb begin
      chunk = '0;
      for (int s = 0; s < STEPS; s++)
        if (k_q == KW'(s)) chunk = grp[s*CHUNK +: CHUNK];
    end
    lgn_class_argmax_lane #(.CHUNK(CHUNK), .SW(SW)) u_lane (
      .clk(clk), .rst_n(rst_n), .clr(clr), .acc(acc),
      .chunk(chunk), .score(scores[c])
    );
  end

  // Score muxes written as compare loops so out-of-range selects give 0.
  always_comb begin
    cur_score = '0;
    score_out = '0;
    for (int c = 0; c < CLASSES; c++) begin
      if (i_q == CW'(c))       cur_score = scores[c];
      if (score_sel == CW'(c)) score_out = scores[c];
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_out_d = class_out_q;
    max_score_d = max_score_q;
    clr         = 1'b0;
    acc         = 1'b0;
    // Strict compare keeps the lowest index on ties.
    nb          = (cur_score > best_q) ? cur_score : best_q;
    ni          = (cur_score > best_q) ? i_q : best_idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d    = S_ACCUM;
          clr        = 1'b1;
          k_d        = '0;
          best_d     = '0;
          best_idx_d = '0;
        end
      end
      S_ACCUM: begin
        acc = 1'b1;
        k_d = k_q + 1'b1;
        if (k_q == KW'(STEPS - 1)) begin
          state_d = S_ARGMAX;
          i_d     = '0;
        end
      end
      S_ARGMAX: begin
        best_d     = nb;
        best_idx_d = ni;
        i_d        = i_q + 1'b1;
        if (i_q == CW'(CLASSES - 1)) begin
          state_d     = S_DONE;
          class_out_d = ni;
          max_score_d = nb;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      i_q         <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_out_q <= '0;
      max_score_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_out_q <= class_out_d;
      max_score_q <= max_score_d;
    end
  end

  assign busy      = (state_q == S_ACCUM) || (state_q == S_ARGMAX);
  assign done      = (state_q == S_DONE);
  assign class_out = class_out_q;
  assign max_score = max_score_q;
endmodule

// File: tb/tb_lgn_class_argmax.sv
module tb_lgn_class_argmax;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance: CLASSES=10, N=400, CHUNK=40
  logic          start_a;
  logic [3999:0] y_a;
  logic [3:0]    sel_a;
  logic          busy_a, done_a;
  logic [3:0]    cls_a;
  logic [8:0]    max_a, sc_a;

  // Small instance: CLASSES=3, N=15, CHUNK=5
  logic          start_b;
  logic [44:0]   y_b;
  logic [1:0]    sel_b;
  logic          busy_b, done_b;
  logic [1:0]    cls_b;
  logic [3:0]    max_b, sc_b;

  lgn_class_argmax dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y(y_a), .score_sel(sel_a),
    .busy(busy_a), .done(done_a), .class_out(cls_a), .max_score(max_a),
    .score_out(sc_a)
  );

  lgn_class_argmax #(.CLASSES(3), .N(15), .CHUNK(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y(y_b), .score_sel(sel_b),
    .busy(busy_b), .done(done_b), .class_out(cls_b), .max_score(max_b),
    .score_out(sc_b)
  );

  typedef struct { int cls; int score; int lat; } exp_t;
  exp_t q_a[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic sb_pop_a(input int lat);
    exp_t e;
    check("sb_nonempty", 32'(q_a.size() > 0), 32'd1);
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("class_out", 32'(cls_a), e.cls);
      check("max_score", 32'(max_a), e.score);
      check("latency", lat, e.lat);
    end
  endtask

  // Pulse start on dut_a and wait (bounded) for its done pulse.
  task automatic run_a(input int ecls, input int escore);
    int n;
    bit seen;
    q_a.push_back('{ecls, escore, 20});
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("busy_after_start", 32'(busy_a), 32'd1);
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done_a) begin
        seen = 1'b1;
        sb_pop_a(n);
        check("busy_in_done", 32'(busy_a), 32'd0);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_a), 32'd0);
  endtask

  function automatic logic [3999:0] one_class(input int c);
    logic [3999:0] v;
    v = '0;
    v[c*400 +: 400] = '1;
    return v;
  endfunction

  initial begin
    int n, ndone;
    bit seen;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    y_a = '0; y_b = '0; sel_a = 4'd0; sel_b = 2'd0;
    repeat (2) @(posedge clk); #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_class", 32'(cls_a), 32'd0);
    check("rst_max", 32'(max_a), 32'd0);
    check("rst_score", 32'(sc_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single winner
    y_a = one_class(3);
    run_a(3, 400);
    sel_a = 4'd3; #1; check("score_sel3", 32'(sc_a), 32'd400);
    sel_a = 4'd4; #1; check("score_sel4", 32'(sc_a), 32'd0);
    sel_a = 4'd15; #1; check("score_sel_oor", 32'(sc_a), 32'd0);

    // Reset mid-ACCUM
    sel_a = 4'd3;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0; #1;
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    check("midrst_class", 32'(cls_a), 32'd0);
    check("midrst_max", 32'(max_a), 32'd0);
    check("midrst_score", 32'(sc_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie across classes 2 and 7 with ones spread over different chunks
    y_a = '0;
    for (int j = 0; j < 100; j++) y_a[2*400 + j*4] = 1'b1;
    for (int j = 0; j < 100; j++) y_a[7*400 + j*3 + 1] = 1'b1;
    for (int j = 0; j < 99; j++)  y_a[5*400 + j*4 + 2] = 1'b1;
    run_a(2, 100);
    sel_a = 4'd5; #1; check("tie_score5", 32'(sc_a), 32'd99);
    sel_a = 4'd7; #1; check("tie_score7", 32'(sc_a), 32'd100);

    // All zero
    y_a = '0;
    run_a(0, 0);

    // Start held high: one done at 20, second back-to-back done at 41
    y_a = one_class(3);
    q_a.push_back('{3, 400, 20});
    q_a.push_back('{7, 400, 41});
    start_a = 1'b1;
    @(posedge clk); #1;
    n = 0; ndone = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      n++;
      if (done_a) begin
        ndone++;
        sb_pop_a(n);
        if (ndone == 1) y_a = one_class(7);
        else start_a = 1'b0;
      end
      if (n == 30) begin
        check("hold_class", 32'(cls_a), 32'd3);
        check("hold_busy", 32'(busy_a), 32'd1);
      end
    end
    start_a = 1'b0;
    check("b2b_done_count", ndone, 32'd2);

    // Small parametrisation
    y_b = '0;
    y_b[6:0]   = '1;
    y_b[29:15] = '1;
    y_b[44:30] = '1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (done_b) seen = 1'b1;
    end
    check("small_done_seen", 32'(seen), 32'd1);
    check("small_latency", n, 32'd6);
    check("small_class", 32'(cls_b), 32'd1);
    check("small_max", 32'(max_b), 32'd15);
    sel_b = 2'd0; #1; check("small_score0", 32'(sc_b), 32'd7);
    sel_b = 2'd3; #1; check("small_score_oor", 32'(sc_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lgn_class_argmax.md
Name: lgn_class_argmax

Overview:
- Multi-cycle per-class popcount and argmax unit for the logic-gate-network classifier.
- Replaces the single flat combinational popcount over all net outputs.
- Splits the net output vector into CLASSES equal groups and popcounts each group CHUNK bits per cycle, so adder depth stays bounded.
- Then scans the class scores sequentially and reports the winning class index and its score. Sits between the net and the chip output pins.

Parameters:
- CLASSES, 10, number of classes; class c owns y[c*N +: N].
- N, 400, net output bits per class.
- CHUNK, 40, bits per class popcounted per cycle; N must be a multiple of CHUNK (elaboration error otherwise).
- Derived: STEPS = N/CHUNK; SW = $clog2(N+1) score width; CW = $clog2(CLASSES) index width (min 1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a classification of current y
- y  input  CLASSES*N  net outputs; must be held stable while busy=1
- score_sel  input  CW  class index for score readback
- busy  output  1  high in ACCUM and ARGMAX
- done  output  1  one-cycle pulse, result valid
- class_out  output  CW  winning class index
- max_score  output  SW  winning class score
- score_out  output  SW  score[score_sel], combinational mux of score registers; 0 if score_sel >= CLASSES

Behaviour:
- Interface: one clock clk. Reset rst_n is asynchronous, active-low. All state is on posedge clk.
- Reset values:
  - state=IDLE, busy=0, done=0, class_out=0, max_score=0.
  - All score registers, step counter k, scan index i, best and best_idx = 0.
- State IDLE:
  - start=1 at an edge -> ACCUM.
  - That edge clears all scores, k=0, best=0, best_idx=0.
- State ACCUM:
  - Each edge, for every class c in parallel: score[c] += popcount(y[c*N + k*CHUNK +: CHUNK]).
  - Popcount width is $clog2(CHUNK+1). No overflow is possible: max N fits SW.
  - k increments each edge. The edge with k=STEPS-1 -> ARGMAX with i=0.
- State ARGMAX:
  - Each edge: if score[i] > best (strict), best<=score[i] and best_idx<=i. Then i increments.
  - The edge with i=CLASSES-1 -> DONE.
  - At that same edge, class_out and max_score load the final best/best_idx, including the i=CLASSES-1 comparison.
  - Ties resolve to the lowest index. All-zero scores give class 0, score 0.
- State DONE:
  - done=1 for exactly this cycle; busy=0.
  - Next edge -> IDLE, or -> ACCUM if start=1 (back-to-back; same clear actions as from IDLE).
- Latency:
  - With start sampled at edge E0, done is high in the cycle after edge E(STEPS+CLASSES). Defaults: 20 edges.
  - busy is high from after E0 through E(STEPS+CLASSES).
- start is ignored while in ACCUM or ARGMAX. It does not restart and does not queue.
- class_out and max_score hold their values from completion until the next completion. They do not change during a new run.
- score registers remain readable via score_out after done until the next accepted start.
- Reset asserted mid-operation: immediate return to the reset values, including class_out and max_score. No done pulse.
- y changing while busy: result undefined. This is a caller obligation, not checked.

Test Plan:
- Reset: assert rst_n=0 mid-ACCUM -> busy=0, done=0, class_out=0, max_score=0, score_out=0 immediately. After release, the next start completes normally.
- Single winner (defaults): class 3 all ones, others zero, pulse start -> done exactly 20 edges later for one cycle; class_out=3, max_score=400. score_sel=3 -> 400; score_sel=4 -> 0.
- Tie and distribution: classes 2 and 7 each have 100 ones spread across different chunks, class 5 has 99 -> class_out=2, max_score=100; score_sel=5 -> 99.
- All zero y -> class_out=0, max_score=0, done after 20 edges.
- Ignored start and back-to-back:
  - start held high for the whole run -> exactly one done at edge 20.
  - Still high in the DONE cycle -> second run begins, second done at edge 41.
  - class_out holds the first result until then.
- Small parametrisation N=15, CHUNK=5, CLASSES=3: class 0 = 7 ones, class 1 = 15, class 2 = 15 -> class_out=1, max_score=15, done 6 edges after start.
